// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared width constants and FSM state encoding for the shift-add multiplier
package mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/acc_clr.sv
// rtl/acc_clr.sv - product accumulation register with synchronous clear, skip-hold and add
module acc_clr #(
  parameter int W2 = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_skip,
  input  logic [W2-1:0] i_addend,
  output logic [W2-1:0] o_acc
);

  logic [W2-1:0] acc_q;
  logic [W2-1:0] acc_d;

  // Clear wins over add; the product cannot overflow 2*WIDTH bits.
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (!i_skip) begin
      acc_d = acc_q + i_addend;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - shift-and-add multiplier sequencer; SHIFT_ADD_MUL_EARLY_TERM_EN enables early exit
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_skip,
  output logic [2*WIDTH-1:0]   o_bit_shifted
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_CLEAR = ST_CLEAR;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_clr_en;
  logic             last_step;
  logic             in_run;
  logic [2*WIDTH-1:0] shift_src;

  assign in_run    = (state_q == S_RUN);
  assign shift_src = {{WIDTH{1'b0}}, a_q};

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain above the current one.
  assign last_step = (cnt_q == LAST_STEP) || (b_q[WIDTH-1:1] == '0);
`else
  assign last_step = (cnt_q == LAST_STEP);
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    acc_clr_en = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_start) begin
          a_d     = i_multiplicand;
          b_d     = i_multiplier;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clr_en = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_skip        = ~in_run | ~b_q[0];
  assign o_bit_shifted = in_run ? (shift_src << cnt_q) : '0;
  assign o_busy        = (state_q == S_CLEAR) || in_run;
  assign o_done        = (state_q == S_DONE);

  acc_clr #(
    .W2(2 * WIDTH)
  ) u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (acc_clr_en),
    .i_skip   (o_skip),
    .i_addend (o_bit_shifted),
    .o_acc    (o_product)
  );

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - directed self-checking bench for shift_add_mul_ctrl
module tb_shift_add_mul_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [15:0] i_multiplicand;
  logic [15:0] i_multiplier;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_product;
  logic        o_skip;
  logic [31:0] o_bit_shifted;

  int n_pass;
  int n_total;
  int lat;
  logic [15:0] skip_vec;
  logic [31:0] bs_k4;

  shift_add_mul_ctrl #(.WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product),
    .o_skip         (o_skip),
    .o_bit_shifted  (o_bit_shifted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [15:0] b);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    int r;
    r = 3;
    for (int i = 0; i < 16; i++) if (b[i]) r = 3 + i;
    return r;
`else
    return 18;
`endif
  endfunction

  function automatic logic [15:0] step_mask(input int l);
    logic [16:0] m;
    m = (17'd1 << (l - 2)) - 17'd1;
    return m[15:0];
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    i_start        = 1'b1;
    i_multiplicand = a;
    i_multiplier   = b;
    tick();
    i_start        = 1'b0;
  endtask

  // k counts cycles after the start edge; the caller is already in cycle k0.
  task automatic wait_done(input int k0, output int l);
    int k;
    k        = k0;
    l        = -1;
    skip_vec = 16'hFFFF;
    bs_k4    = 32'hDEAD_BEEF;
    while (k <= 40) begin
      if (o_done) begin
        l = k;
        break;
      end
      if (k >= 2 && k <= 17) skip_vec[k-2] = o_skip;
      if (k == 4) bs_k4 = o_bit_shifted;
      k++;
      tick();
    end
    if (l < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_product"}, o_product, 32'd0);
    chk({tag, "_skip"}, {31'd0, o_skip}, 32'd1);
    chk({tag, "_bitsh"}, o_bit_shifted, 32'd0);
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    reset_n        = 1'b0;
    i_start        = 1'b0;
    i_multiplicand = 16'h0;
    i_multiplier   = 16'h0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();
    check_reset_outputs("idle");

    // 3 * 5: alternating skip pattern, shifted multiplicand visible at cnt=2
    start_op(16'd3, 16'd5);
    chk("t1_clear_busy", {31'd0, o_busy}, 32'd1);
    wait_done(1, lat);
    chk("t1_lat", lat, exp_lat(16'd5));
    chk("t1_prod", o_product, 32'd15);
    chk("t1_skip", {16'd0, skip_vec & step_mask(lat)}, {16'd0, 16'hFFFA & step_mask(lat)});
    chk("t1_bitsh", bs_k4, 32'd12);
    tick();
    chk("t1_done_pulse", {31'd0, o_done}, 32'd0);
    chk("t1_busy_after", {31'd0, o_busy}, 32'd0);
    chk("t1_hold", o_product, 32'd15);

    // maximum operands
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(1, lat);
    chk("t2_lat", lat, 32'd18);
    chk("t2_prod", o_product, 32'hFFFE_0001);
    chk("t2_noskip", {16'd0, skip_vec}, 32'd0);
    tick();

    start_op(16'd7, 16'd1);
    wait_done(1, lat);
    chk("t3_lat", lat, exp_lat(16'd1));
    chk("t3_prod", o_product, 32'd7);
    tick();

    start_op(16'd7, 16'd0);
    wait_done(1, lat);
    chk("t4_lat", lat, exp_lat(16'd0));
    chk("t4_prod", o_product, 32'd0);
    tick();

    start_op(16'd7, 16'h8000);
    wait_done(1, lat);
    chk("t5_lat", lat, 32'd18);
    chk("t5_prod", o_product, 32'h0003_8000);
    tick();

    // start pulse during RUN must be ignored
    start_op(16'd5, 16'd6);
    tick();
    tick();
    i_start        = 1'b1;
    i_multiplicand = 16'd9;
    i_multiplier   = 16'd9;
    tick();
    i_start        = 1'b0;
    wait_done(4, lat);
    chk("t6_lat", lat, exp_lat(16'd6));
    chk("t6_prod", o_product, 32'd30);

    // start held in DONE chains straight into the next CLEAR
    i_start        = 1'b1;
    i_multiplicand = 16'd11;
    i_multiplier   = 16'd13;
    tick();
    i_start        = 1'b0;
    chk("t7_b2b_busy", {31'd0, o_busy}, 32'd1);
    chk("t7_b2b_done", {31'd0, o_done}, 32'd0);
    wait_done(1, lat);
    chk("t7_lat", lat, exp_lat(16'd13));
    chk("t7_prod", o_product, 32'd143);
    tick();

    // asynchronous reset in the middle of RUN
    start_op(16'd7, 16'd9);
    repeat (5) tick();
    chk("t8_pre_busy", {31'd0, o_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t8_async");
    tick();
    check_reset_outputs("t8_next");
    tick();
    chk("t8_no_done", {31'd0, o_done}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("t8_idle_done", {31'd0, o_done}, 32'd0);
    start_op(16'd12, 16'd10);
    wait_done(1, lat);
    chk("t9_lat", lat, exp_lat(16'd10));
    chk("t9_prod", o_product, 32'd120);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
